// File: rtl/dma_bus_arbiter.sv
// Shares the board's single UNIBUS DMA port among NREQ bus masters, with fixed or
// round-robin priority and an idle watchdog that reclaims the bus from silent masters.
module dma_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int RR_MODE = 1,
  parameter int TMO_W   = 8
) (
  input  logic                 clk_p,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      dev_req,
  output logic [NREQ-1:0]      dev_gnt,
  input  logic [18*NREQ-1:0]   dev_adr18,
  input  logic [NREQ-1:0]      dev_stb,
  output logic                 dma_req,
  input  logic                 dma_ack,
  output logic [17:0]          dma_adr18,
  output logic                 dma_stb,
  input  logic                 tmo_clr,
  output logic                 tmo_err,
  output logic                 busy
);

  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Last counter value before the limit 2^TMO_W-1 is reached.
  localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, ARB_WAIT, GRANT, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    mask_q, mask_d;
  logic [NREQ-1:0]    dev_gnt_q, dev_gnt_d;
  logic               dma_req_q, dma_req_d;
  logic               tmo_err_q, tmo_err_d;
  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    sel_onehot;
  logic [SEL_W-1:0]   sel_next;
  logic               tmo_set;

  function automatic logic [SEL_W-1:0] pick_winner(input logic [NREQ-1:0] elig,
                                                   input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] win;
    logic             found;
    int               idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(start) + k) % NREQ;
      if (!found && elig[idx]) begin
        win   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      dev_gnt_q <= '0;
      dma_req_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      dev_gnt_q <= dev_gnt_d;
      dma_req_q <= dma_req_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign eligible   = dev_req & ~mask_q;
  assign sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;
  assign sel_next   = (sel_q == SEL_W'(NREQ-1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    dev_gnt_d = dev_gnt_q;
    dma_req_d = dma_req_q;
    tmo_set   = 1'b0;
    // A timed-out master stays masked until it lets go of its request.
    mask_d    = mask_q & dev_req;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          sel_d     = pick_winner(eligible, (RR_MODE != 0) ? ptr_q : '0);
          dma_req_d = 1'b1;
          state_d   = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (!dev_req[sel_q]) begin
          dma_req_d = 1'b0;
          state_d   = RELEASE;
        end else if (dma_ack) begin
          dev_gnt_d = sel_onehot;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        cnt_d = dev_stb[sel_q] ? '0 : cnt_q + 1'b1;
        if (!dev_req[sel_q] || !dma_ack) begin
          dev_gnt_d = '0;
          dma_req_d = 1'b0;
          state_d   = RELEASE;
        end else if (!dev_stb[sel_q] && (cnt_q == CNT_LAST)) begin
          tmo_set       = 1'b1;
          mask_d[sel_q] = 1'b1;
          dev_gnt_d     = '0;
          dma_req_d     = 1'b0;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        if (!dma_ack) begin
          if (RR_MODE != 0) ptr_d = sel_next;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tmo_err_d = tmo_set | (tmo_err_q & ~tmo_clr);
  end

  always_comb begin
    dma_adr18 = '0;
    dma_stb   = 1'b0;
    if (dev_gnt_q[sel_q]) begin
      dma_adr18 = dev_adr18[int'(sel_q)*18 +: 18];
      dma_stb   = dev_stb[sel_q];
    end
    busy = (state_q != IDLE);
  end

  assign dev_gnt = dev_gnt_q;
  assign dma_req = dma_req_q;
  assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with shared stimulus and checks
// both every cycle against a transaction-level model of bus ownership.
module tb_dma_bus_arbiter;
  localparam int NREQ  = 4;
  localparam int TMO_W = 8;
  localparam int LIMIT = (1 << TMO_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [3:0]  req, stb;
  logic [71:0] adr;
  logic        ack, clr;

  logic [3:0]  gnt_f, gnt_r;
  logic        req_f, req_r, stb_f, stb_r, err_f, err_r, busy_f, busy_r;
  logic [17:0] adr_f, adr_r;

  dma_bus_arbiter #(.NREQ(NREQ), .RR_MODE(0), .TMO_W(TMO_W)) u_fx (
    .clk_p(clk), .rst_n(rstn), .dev_req(req), .dev_gnt(gnt_f), .dev_adr18(adr),
    .dev_stb(stb), .dma_req(req_f), .dma_ack(ack), .dma_adr18(adr_f), .dma_stb(stb_f),
    .tmo_clr(clr), .tmo_err(err_f), .busy(busy_f));

  dma_bus_arbiter #(.NREQ(NREQ), .RR_MODE(1), .TMO_W(TMO_W)) u_rr (
    .clk_p(clk), .rst_n(rstn), .dev_req(req), .dev_gnt(gnt_r), .dev_adr18(adr),
    .dev_stb(stb), .dma_req(req_r), .dma_ack(ack), .dma_adr18(adr_r), .dma_stb(stb_r),
    .tmo_clr(clr), .tmo_err(err_r), .busy(busy_r));

  int n_tests = 0;
  int n_fail  = 0;

  // Ownership model, index 0 = fixed priority, 1 = round-robin.
  int       m_sel[2], m_owner[2], m_ptr[2], m_quiet[2];
  bit       m_bus_req[2], m_pending[2], m_cooling[2], m_err[2];
  bit [3:0] m_mask[2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int firstEligible(input bit [3:0] elig, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (start + k) % NREQ;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelStep(input int m);
    bit [3:0] keep;
    bit       set_err;
    int       g, w;
    if (!rstn) begin
      m_sel[m] = 0; m_owner[m] = -1; m_ptr[m] = 0; m_quiet[m] = 0;
      m_bus_req[m] = 0; m_pending[m] = 0; m_cooling[m] = 0; m_err[m] = 0; m_mask[m] = 0;
      return;
    end
    keep    = m_mask[m] & req;
    set_err = 0;
    g       = m_owner[m];
    if (m_cooling[m]) begin
      if (!ack) begin
        m_cooling[m] = 0;
        if (m == 1) m_ptr[m] = (m_sel[m] + 1) % NREQ;
      end
    end else if (m_pending[m]) begin
      if (!req[m_sel[m]]) begin
        m_pending[m] = 0; m_bus_req[m] = 0; m_cooling[m] = 1;
      end else if (ack) begin
        m_pending[m] = 0; m_owner[m] = m_sel[m]; m_quiet[m] = 0;
      end
    end else if (g >= 0) begin
      if (!req[g] || !ack) begin
        m_owner[m] = -1; m_bus_req[m] = 0; m_cooling[m] = 1;
      end else if (!stb[g] && (m_quiet[m] + 1 >= LIMIT)) begin
        set_err = 1; keep[g] = 1'b1;
        m_owner[m] = -1; m_bus_req[m] = 0; m_cooling[m] = 1;
      end else begin
        m_quiet[m] = stb[g] ? 0 : m_quiet[m] + 1;
      end
    end else begin
      w = firstEligible(req & ~m_mask[m], (m == 1) ? m_ptr[m] : 0);
      if (w >= 0) begin
        m_sel[m] = w; m_bus_req[m] = 1; m_pending[m] = 1;
      end
    end
    m_mask[m] = keep;
    m_err[m]  = set_err ? 1'b1 : (clr ? 1'b0 : m_err[m]);
  endtask

  task automatic checkAll();
    for (int m = 0; m < 2; m++) begin
      logic [3:0]  eg;
      logic [17:0] ea;
      logic        es;
      string       p;
      p  = (m == 1) ? "rr" : "fx";
      eg = '0; ea = '0; es = 1'b0;
      if (m_owner[m] >= 0) begin
        eg[m_owner[m]] = 1'b1;
        ea = adr[m_owner[m]*18 +: 18];
        es = stb[m_owner[m]];
      end
      checkOutput({p, "_dev_gnt"},   (m == 1) ? gnt_r  : gnt_f,  eg);
      checkOutput({p, "_dma_req"},   (m == 1) ? req_r  : req_f,  m_bus_req[m]);
      checkOutput({p, "_dma_adr18"}, (m == 1) ? adr_r  : adr_f,  ea);
      checkOutput({p, "_dma_stb"},   (m == 1) ? stb_r  : stb_f,  es);
      checkOutput({p, "_tmo_err"},   (m == 1) ? err_r  : err_f,  m_err[m]);
      checkOutput({p, "_busy"},      (m == 1) ? busy_r : busy_f,
                  m_pending[m] | m_cooling[m] | (m_owner[m] >= 0));
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      modelStep(0);
      modelStep(1);
      #1;
      checkAll();
    end
  endtask

  task automatic doReset();
    rstn = 1'b0; ack = 1'b0;
    applyStimulus(1);
    rstn = 1'b1;
  endtask

  task automatic waitGrant(input int bound, input string tag);
    int k;
    k = 0;
    while (gnt_r == 4'b0 && k < bound) begin
      ack = req_r;
      applyStimulus(1);
      k++;
    end
    checkOutput({tag, "_grant_seen"}, gnt_r != 4'b0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int       held[4];
    int       order[$];
    int       exp_order[5];
    int       low_run, cnt, regrant;
    bit       prev_req, seen;
    logic [3:0] prev_gnt;

    rstn = 1'b0; req = '0; stb = '0; adr = '0; ack = 1'b0; clr = 1'b0;
    applyStimulus(2);
    checkOutput("rst_dma_req", req_r, 0);
    checkOutput("rst_dev_gnt", gnt_r, 0);
    checkOutput("rst_tmo_err", err_f, 0);
    checkOutput("rst_busy", busy_f, 0);
    rstn = 1'b1;
    applyStimulus(1);

    // Fixed/RR from reset: request, delayed ack, zero-latency address mux.
    adr[18 +: 18] = 18'o123456;
    req = 4'b1010;
    applyStimulus(1);
    checkOutput("s1_dma_req_fx", req_f, 1);
    checkOutput("s1_dma_req_rr", req_r, 1);
    applyStimulus(2);
    ack = 1'b1;
    applyStimulus(1);
    checkOutput("s1_gnt_fx", gnt_f, 4'b0010);
    checkOutput("s1_gnt_rr", gnt_r, 4'b0010);
    stb = 4'b1010;
    #1;
    checkOutput("s1_adr_fx", adr_f, 18'o123456);
    checkOutput("s1_stb_fx", stb_f, 1);
    applyStimulus(3);
    req = 4'b0000;
    applyStimulus(1);
    checkOutput("s1_release", gnt_f, 0);
    ack = 1'b0; stb = '0;
    applyStimulus(3);

    // Round-robin rotation with every master requesting.
    doReset();
    req = 4'b1111;
    held = '{default: 0};
    low_run = 0; prev_req = 0; seen = 0; prev_gnt = '0;
    repeat (80) begin
      if (gnt_r != 4'b0 && prev_gnt == 4'b0)
        for (int i = 0; i < NREQ; i++) if (gnt_r[i]) order.push_back(i);
      if (req_r && !prev_req && seen) checkOutput("rr_gap_ge2", low_run >= 2, 1);
      if (req_r && !prev_req) seen = 1;
      low_run  = req_r ? 0 : low_run + 1;
      prev_req = req_r;
      prev_gnt = gnt_r;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_r[i]) begin
          held[i]++;
          if (held[i] == 5) begin req[i] = 1'b0; held[i] = 0; end
        end else if (!req[i]) begin
          req[i] = 1'b1;
        end
      end
      ack = req_r;
      applyStimulus(1);
    end
    exp_order = '{0, 1, 2, 3, 0};
    checkOutput("rr_grant_count", order.size() >= 5, 1);
    for (int i = 0; i < 5 && i < order.size(); i++) checkOutput("rr_order", order[i], exp_order[i]);
    req = '0;
    repeat (5) begin ack = req_r; applyStimulus(1); end

    // Watchdog: device 2 holds the bus without strobing.
    doReset();
    req = 4'b0100; stb = '0;
    waitGrant(10, "s3");
    cnt = 0;
    while (gnt_r != 4'b0 && cnt < 300) begin
      cnt++;
      ack = req_r;
      applyStimulus(1);
    end
    checkOutput("s3_hold_cycles", cnt, LIMIT);
    checkOutput("s3_tmo_err", err_r, 1);
    checkOutput("s3_gnt_off", gnt_r, 0);
    checkOutput("s3_dma_req_off", req_r, 0);
    regrant = 0;
    repeat (30) begin
      ack = req_r;
      applyStimulus(1);
      if (gnt_r != 4'b0) regrant++;
    end
    checkOutput("s3_no_regrant", regrant, 0);
    req = 4'b0000; ack = req_r;
    applyStimulus(1);
    req = 4'b0100;
    waitGrant(10, "s3_regrant");
    clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0;
    checkOutput("s3_tmo_clr", err_r, 0);
    req = '0;
    repeat (4) begin ack = req_r; applyStimulus(1); end

    // Request withdrawn before acknowledge.
    doReset();
    req = 4'b0001;
    applyStimulus(1);
    checkOutput("s4_req_up", req_r, 1);
    req = 4'b0000;
    applyStimulus(1);
    checkOutput("s4_req_fall", req_r, 0);
    ack = 1'b1;
    repeat (2) begin
      applyStimulus(1);
      checkOutput("s4_no_gnt", gnt_r, 0);
      checkOutput("s4_busy_hold", busy_r, 1);
    end
    ack = 1'b0;
    applyStimulus(1);
    checkOutput("s4_idle", busy_r, 0);

    // CPU aborts by dropping acknowledge during a grant.
    doReset();
    req = 4'b0001;
    waitGrant(10, "s5");
    ack = 1'b0;
    applyStimulus(1);
    checkOutput("s5_gnt_off", gnt_r, 0);
    checkOutput("s5_no_err", err_r, 0);
    req = '0;
    applyStimulus(3);

    // Reset while a master owns the bus.
    doReset();
    req = 4'b0001; stb = 4'b0001;
    waitGrant(10, "s6");
    checkOutput("s6_stb_on", stb_r, 1);
    rstn = 1'b0;
    applyStimulus(1);
    checkOutput("s6_dma_req", req_r, 0);
    checkOutput("s6_gnt", gnt_r, 0);
    checkOutput("s6_stb", stb_r, 0);
    checkOutput("s6_busy", busy_r, 0);
    rstn = 1'b1; req = '0; stb = '0;
    applyStimulus(2);

    // Random traffic with occasional protocol glitches.
    repeat (2000) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        adr[i*18 +: 18] = 18'($urandom);
      end
      stb  = 4'($urandom);
      ack  = ($urandom_range(7) == 0) ? 1'($urandom_range(1)) : req_r;
      clr  = ($urandom_range(31) == 0);
      rstn = ($urandom_range(499) != 0);
      applyStimulus(1);
    end

    // Quiet masters so the watchdog fires repeatedly.
    rstn = 1'b1; clr = 1'b0;
    repeat (1500) begin
      for (int i = 0; i < NREQ; i++) if ($urandom_range(63) == 0) req[i] = ~req[i];
      stb = ($urandom_range(63) == 0) ? 4'($urandom) : 4'b0;
      ack = ($urandom_range(63) == 0) ? 1'($urandom_range(1)) : req_r;
      clr = ($urandom_range(127) == 0);
      applyStimulus(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
